// File: rtl/branch_target_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : branch_target_buffer                                   |
// | Description : Fully-associative branch target buffer. Lookup is      |
// |               combinational; execute-stage resolutions train the     |
// |               per-entry saturating counters and allocate new entries |
// |               (free slot first, else round-robin victim).            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module branch_target_buffer #(
  parameter int PC_W     = 16,
  parameter int ENTRIES  = 4,
  parameter int CNT_W    = 2,
  parameter int ALLOC_NT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PC_W-1:0]             lookup_pc,
  output logic                        hit,
  output logic                        pred_taken,
  output logic [PC_W-1:0]             pred_target,
  input  logic                        upd_valid,
  input  logic [PC_W-1:0]             upd_pc,
  input  logic                        upd_taken,
  input  logic [PC_W-1:0]             upd_target,
  input  logic                        clear,
  output logic [$clog2(ENTRIES):0]    occupancy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  // Entry storage
  logic [ENTRIES-1:0] r_valid;
  logic [PC_W-1:0]    r_tag    [ENTRIES];
  logic [PC_W-1:0]    r_target [ENTRIES];
  logic [CNT_W-1:0]   r_cnt    [ENTRIES];
  logic [IDX_W-1:0]   r_victim;
  logic [OCC_W-1:0]   r_occ;

  // Lookup/update match results and allocation choice
  logic               w_look_hit;
  logic [IDX_W-1:0]   w_look_idx;
  logic               w_upd_hit;
  logic [IDX_W-1:0]   w_upd_idx;
  logic               w_has_free;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_alloc_en;
  logic [IDX_W-1:0]   w_alloc_idx;

  // Lookup match: scanning from the top down lets the lowest index win
  always_comb begin
    w_look_hit = 1'b0;
    w_look_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == lookup_pc)) begin
        w_look_hit = 1'b1;
        w_look_idx = IDX_W'(i);
      end
    end
  end

  // Update match: same lowest-index priority, only valid entries count
  always_comb begin
    w_upd_hit = 1'b0;
    w_upd_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == upd_pc)) begin
        w_upd_hit = 1'b1;
        w_upd_idx = IDX_W'(i);
      end
    end
  end

  // Lowest-index invalid slot, and the final allocation target
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_has_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
    w_alloc_idx = w_has_free ? w_free_idx : r_victim;
    w_alloc_en  = upd_valid && !w_upd_hit && (upd_taken || (ALLOC_NT != 0));
  end

  // Prediction outputs are forced to zero on a miss
  always_comb begin
    hit         = w_look_hit;
    pred_taken  = w_look_hit & r_cnt[w_look_idx][CNT_W-1];
    pred_target = w_look_hit ? r_target[w_look_idx] : '0;
    occupancy   = r_occ;
  end

  // Entry state: async reset, clear beats update, then train or allocate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= '0;
      r_victim <= '0;
      r_occ    <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= '0;
      end
    end else if (clear) begin
      // Counters and targets stay; the valid bits alone gate their use
      r_valid  <= '0;
      r_victim <= '0;
      r_occ    <= '0;
    end else if (upd_valid) begin
      if (w_upd_hit) begin
        if (upd_taken) begin
          if (r_cnt[w_upd_idx] != C_CNT_MAX) begin
            r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] + CNT_W'(1);
          end
          r_target[w_upd_idx] <= upd_target;
        end else if (r_cnt[w_upd_idx] != '0) begin
          r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] - CNT_W'(1);
        end
      end else if (w_alloc_en) begin
        r_valid[w_alloc_idx]  <= 1'b1;
        r_tag[w_alloc_idx]    <= upd_pc;
        r_target[w_alloc_idx] <= upd_target;
        r_cnt[w_alloc_idx]    <= upd_taken ? C_CNT_MAX : '0;
        if (w_has_free) begin
          // Only a free slot grows occupancy, so it can never exceed ENTRIES
          r_occ <= r_occ + OCC_W'(1);
        end else begin
          // ENTRIES is a power of two, so natural overflow wraps to 0
          r_victim <= r_victim + IDX_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter PC_W, default 16, meaning PC and target width in bits.
REQ-002 SHALL have parameter ENTRIES, default 4, meaning number of BTB entries; legal values are powers of two from 2 to 16.
REQ-003 SHALL have parameter CNT_W, default 2, meaning width of the per-entry saturating history counter; legal values are 1 to 4.
REQ-004 SHALL have parameter ALLOC_NT, default 1, meaning 1 = allocate on any resolved branch, 0 = allocate only on taken branches.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 lookup_pc  in  PC_W  fetch-stage PC to predict.
REQ-009 hit  out  1  lookup_pc matches a valid entry.
REQ-010 pred_taken  out  1  MSB of the matching entry's counter; 0 on miss.
REQ-011 pred_target  out  PC_W  stored target of the matching entry; 0 on miss.
REQ-012 upd_valid  in  1  execute-stage branch/jump resolved this cycle.
REQ-013 upd_pc  in  PC_W  PC of the resolved branch.
REQ-014 upd_taken  in  1  resolved direction.
REQ-015 upd_target  in  PC_W  computed branch target.
REQ-016 clear  in  1  synchronous invalidate-all.
REQ-017 occupancy  out  $clog2(ENTRIES)+1  count of valid entries.

Function
REQ-018 SHALL perform lookup combinationally, with zero latency from lookup_pc to hit, pred_taken and pred_target.
REQ-019 SHALL keep at most one valid entry per PC; if a match is ever multiple, the lowest index SHALL win.
REQ-020 SHALL return pre-update state on lookup when an update to the same PC occurs in the same cycle (no bypass).
REQ-021 SHALL, on upd_valid with a hit on upd_pc, increment the counter (saturating at 2^CNT_W-1) if taken, else decrement it (saturating at 0).
REQ-022 SHALL, on an updating hit, overwrite target with upd_target only when upd_taken=1.
REQ-023 SHALL, on upd_valid with a miss, allocate when upd_taken=1 or ALLOC_NT=1, and otherwise do nothing.
REQ-024 SHALL initialise an allocated entry with valid=1, tag=upd_pc and target=upd_target, and with counter=all-ones if taken, else 0.
REQ-025 SHALL choose the allocation slot as the lowest-index invalid entry; the victim pointer SHALL be unchanged in that case.
REQ-026 SHALL, when all entries are valid, allocate at the victim pointer, then advance the pointer by 1 modulo ENTRIES (wrap ENTRIES-1 to 0).
REQ-027 SHALL make occupancy increment by 1 on allocation into an invalid slot, stay unchanged on replacement or hit-update, and saturate at ENTRIES.
REQ-028 SHALL give clear priority over upd_valid in the same cycle: all valid bits to 0, occupancy to 0, victim pointer to 0, with the update dropped.
REQ-029 SHALL leave counters and targets unchanged on clear; only valid bits gate use.
REQ-030 SHALL treat an X-free upd_pc equal to an invalid entry's stale tag as a miss.

Reset
REQ-031 SHALL, on rst_n low, immediately clear all valid bits, counters, tags and targets to 0, the victim pointer to 0 and occupancy to 0, independent of clk.
REQ-032 SHALL drive hit=0, pred_taken=0 and pred_target=0 while in reset.
REQ-033 SHALL ignore upd_valid and clear while rst_n is low, and resume on the first rising clk edge after rst_n rises.
REQ-034 SHALL, when reset asserts mid-update, leave no partial entry; all state reads reset values.

Verification (defaults: PC_W=16, ENTRIES=4, CNT_W=2, ALLOC_NT=1)
REQ-035 Reset, then upd pc=0x0010 taken tgt=0x0040, then lookup 0x0010 -> hit=1, pred_taken=1, pred_target=0x0040, occupancy=1.
REQ-036 Entry 0x0010 at counter 3; two not-taken updates -> counter 1, pred_taken=0, target still 0x0040; two more not-taken -> counter stays 0.
REQ-037 Allocate PCs 0x10, 0x20, 0x30, 0x40, then 0x50 and 0x60 -> 0x50 replaces slot 0 and 0x60 replaces slot 1; lookup 0x10 misses, occupancy=4.
REQ-038 ALLOC_NT=0: not-taken update of 0x0070 on miss -> no allocation, occupancy unchanged; taken update -> allocates with counter=3.
REQ-039 clear and upd_valid in the same cycle -> all lookups miss, occupancy=0, and the next allocation goes to slot 0.
REQ-040 Assert rst_n low between clock edges with entries valid -> hit drops to 0 without a clock edge; occupancy=0 after release.
